conv_layer_mem_resp: RTL and testbench

Memory-side responder for the convolution engine's layer-memory interface (cwr/caddr_wr/cdata_wr, crd/caddr_rd/cdata_rd, csel).
- Decodes csel into five logical banks and maps them onto one external single-port SRAM with 1-cycle read latency.
- Returns read data with fixed latency.
- Tracks per-bank write completion and flags protocol errors for the controller and the bench.

---
 rtl/conv_pkg.sv | 43 ++++
 rtl/conv_bank_decode.sv | 28 ++
 rtl/conv_layer_mem_resp.sv | 156 +++++++++++++++
 tb/tb_conv_layer_mem_resp.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer-memory responder.
// Holds the data/address widths, the csel bank encodings and the
// per-bank base/size lookup used by the decoder and the write counters.
package conv_pkg;

    localparam int DW    = 20;   // layer word width
    localparam int AW    = 12;   // engine-side address width
    localparam int SAW   = 14;   // SRAM address width
    localparam int CW    = 13;   // write counter width (holds 4096)
    localparam int NBANK = 5;

    localparam int L0_SIZE = 4096;
    localparam int L1_SIZE = 1024;
    localparam int L2_SIZE = 2048;

    localparam logic [2:0] CSEL_L0M0 = 3'b001;
    localparam logic [2:0] CSEL_L0M1 = 3'b010;
    localparam logic [2:0] CSEL_L1M0 = 3'b011;
    localparam logic [2:0] CSEL_L1M1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    // Bank index 0..4 follows csel-1 ordering (L0_MEM0 first).
    function automatic logic [SAW-1:0] bank_base(input logic [2:0] idx);
        case (idx)
            3'd0:    bank_base = 14'd0;
            3'd1:    bank_base = 14'd4096;
            3'd2:    bank_base = 14'd8192;
            3'd3:    bank_base = 14'd9216;
            3'd4:    bank_base = 14'd10240;
            default: bank_base = 14'd0;
        endcase
    endfunction

    function automatic logic [CW-1:0] bank_size(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: bank_size = CW'(L0_SIZE);
            3'd2, 3'd3: bank_size = CW'(L1_SIZE);
            3'd4:       bank_size = CW'(L2_SIZE);
            default:    bank_size = '0;
        endcase
    endfunction

endpackage

// File: rtl/conv_bank_decode.sv
// Combinational bank decoder.
// Ports:
//   csel      - bank select from the engine
//   addr      - word address within the selected bank
//   legal     - csel names one of the five banks
//   in_range  - legal and addr below the bank size
//   bank_idx  - 0..4 (0 when csel is illegal)
//   sram_addr - physical SRAM address (bank base + addr)
module conv_bank_decode
    import conv_pkg::*;
(
    input  logic [2:0]     csel,
    input  logic [AW-1:0]  addr,
    output logic           legal,
    output logic           in_range,
    output logic [2:0]     bank_idx,
    output logic [SAW-1:0] sram_addr
);

    always_comb begin
        legal     = (csel >= CSEL_L0M0) && (csel <= CSEL_L2);
        bank_idx  = legal ? (csel - 3'd1) : 3'd0;
        in_range  = legal && ({1'b0, addr} < bank_size(bank_idx));
        // Cannot overflow once in_range holds: largest sum is 12287.
        sram_addr = bank_base(bank_idx) + {{(SAW-AW){1'b0}}, addr};
    end

endmodule

// File: rtl/conv_layer_mem_resp.sv
// Layer-memory responder: maps the engine's five logical banks onto one
// single-port SRAM with 1-cycle read latency.
// Pipeline: R (request register) -> S (SRAM access) -> D (read data capture).
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   cwr/caddr_wr/cdata_wr      - write request
//   crd/caddr_rd               - read request
//   csel                       - bank select shared by both ports
//   cdata_rd/cdata_rd_vld      - registered read data and its 1-cycle strobe
//   sram_*                     - external SRAM interface
//   clr_status                 - clears counters, bank_full and error flags
//   bank_full, err_*           - sticky status
module conv_layer_mem_resp
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cwr,
    input  logic [AW-1:0]    caddr_wr,
    input  logic [DW-1:0]    cdata_wr,
    input  logic             crd,
    input  logic [AW-1:0]    caddr_rd,
    output logic [DW-1:0]    cdata_rd,
    output logic             cdata_rd_vld,
    input  logic [2:0]       csel,
    output logic             sram_ce,
    output logic             sram_we,
    output logic [SAW-1:0]   sram_addr,
    output logic [DW-1:0]    sram_wdata,
    input  logic [DW-1:0]    sram_rdata,
    input  logic             clr_status,
    output logic [NBANK-1:0] bank_full,
    output logic             err_coll,
    output logic             err_sel,
    output logic             err_range
);

    logic           wr_legal, wr_in_range, rd_legal, rd_in_range;
    logic [2:0]     wr_idx, rd_idx;
    logic [SAW-1:0] wr_saddr, rd_saddr;

    conv_bank_decode u_wr_dec (
        .csel      (csel),
        .addr      (caddr_wr),
        .legal     (wr_legal),
        .in_range  (wr_in_range),
        .bank_idx  (wr_idx),
        .sram_addr (wr_saddr)
    );

    conv_bank_decode u_rd_dec (
        .csel      (csel),
        .addr      (caddr_rd),
        .legal     (rd_legal),
        .in_range  (rd_in_range),
        .bank_idx  (rd_idx),
        .sram_addr (rd_saddr)
    );

    logic           any_req, eff_legal, eff_in_range, accept, wr_acc;
    logic [2:0]     eff_idx;
    logic           req_vld_q, req_vld_d, req_we_q, req_we_d;
    logic [SAW-1:0] req_addr_q, req_addr_d;
    logic [DW-1:0]  req_wdata_q, req_wdata_d;
    logic           rd_pend_q, rd_pend_d;
    logic [DW-1:0]  cdata_rd_q, cdata_rd_d;
    logic           rd_vld_q, rd_vld_d;
    logic           err_coll_q, err_coll_d, err_sel_q, err_sel_d;
    logic           err_range_q, err_range_d;

    always_comb begin
        // A simultaneous write takes the slot; the read is simply discarded.
        any_req      = cwr | crd;
        eff_legal    = cwr ? wr_legal    : rd_legal;
        eff_in_range = cwr ? wr_in_range : rd_in_range;
        eff_idx      = cwr ? wr_idx      : rd_idx;
        accept       = any_req & eff_legal & eff_in_range;
        wr_acc       = accept & cwr;

        req_vld_d    = accept;
        req_we_d     = cwr;
        req_addr_d   = cwr ? wr_saddr : rd_saddr;
        req_wdata_d  = cdata_wr;

        // A read in stage S this cycle has its SRAM data ready next cycle.
        rd_pend_d    = req_vld_q & ~req_we_q;
        rd_vld_d     = rd_pend_q;
        cdata_rd_d   = rd_pend_q ? sram_rdata : cdata_rd_q;

        // Clear dominates any flag raised in the same cycle.
        err_coll_d   = ~clr_status & (err_coll_q  | (cwr & crd));
        err_sel_d    = ~clr_status & (err_sel_q   | (any_req & ~eff_legal));
        err_range_d  = ~clr_status & (err_range_q | (any_req & eff_legal & ~eff_in_range));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_vld_q   <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
            cdata_rd_q  <= '0;
            err_coll_q  <= 1'b0;
            err_sel_q   <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            req_vld_q   <= req_vld_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rd_vld_q    <= rd_vld_d;
            cdata_rd_q  <= cdata_rd_d;
            err_coll_q  <= err_coll_d;
            err_sel_q   <= err_sel_d;
            err_range_q <= err_range_d;
        end
    end

    // Per-bank write counters, saturating at the bank size.
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_cnt
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_status) begin
                cnt_d = '0;
            end else if (wr_acc && (eff_idx == 3'(gi)) && (cnt_q != bank_size(3'(gi)))) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign bank_full[gi] = (cnt_q == bank_size(3'(gi)));
    end

    assign sram_ce      = req_vld_q;
    assign sram_we      = req_we_q;
    assign sram_addr    = req_addr_q;
    assign sram_wdata   = req_wdata_q;
    assign cdata_rd     = cdata_rd_q;
    assign cdata_rd_vld = rd_vld_q;
    assign err_coll     = err_coll_q;
    assign err_sel      = err_sel_q;
    assign err_range    = err_range_q;

endmodule

// File: tb/tb_conv_layer_mem_resp.sv
// Testbench for conv_layer_mem_resp: directed scenarios followed by a
// randomized phase, all checked every cycle against a bank-level model
// (per-bank memory images, a timed queue of read returns, plain counters).
module tb_conv_layer_mem_resp;
    import conv_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             cwr, crd, clr_status;
    logic [AW-1:0]    caddr_wr, caddr_rd;
    logic [DW-1:0]    cdata_wr;
    logic [2:0]       csel;
    logic [DW-1:0]    cdata_rd;
    logic             cdata_rd_vld;
    logic             sram_ce, sram_we;
    logic [SAW-1:0]   sram_addr;
    logic [DW-1:0]    sram_wdata;
    logic [DW-1:0]    sram_rdata;
    logic [NBANK-1:0] bank_full;
    logic             err_coll, err_sel, err_range;

    always #5 clk = ~clk;

    conv_layer_mem_resp dut (
        .clk          (clk),
        .reset        (reset),
        .cwr          (cwr),
        .caddr_wr     (caddr_wr),
        .cdata_wr     (cdata_wr),
        .crd          (crd),
        .caddr_rd     (caddr_rd),
        .cdata_rd     (cdata_rd),
        .cdata_rd_vld (cdata_rd_vld),
        .csel         (csel),
        .sram_ce      (sram_ce),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .clr_status   (clr_status),
        .bank_full    (bank_full),
        .err_coll     (err_coll),
        .err_sel      (err_sel),
        .err_range    (err_range)
    );

    // External single-port SRAM, registered read.
    logic [DW-1:0] sram_mem [2**SAW];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    int            size_tab [NBANK] = '{4096, 4096, 1024, 1024, 2048};
    int            base_tab [NBANK];
    logic [DW-1:0] img [NBANK][4096];
    rd_t           rdq [$];
    int            cnt [NBANK];
    int            cyc;
    bit            e_coll, e_sel, e_range;
    bit            exp_ce, exp_we, exp_vld;
    int            exp_addr;
    logic [DW-1:0] exp_wdata, exp_cdata;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        rdq.delete();
        for (int i = 0; i < NBANK; i++) cnt[i] = 0;
        e_coll = 0; e_sel = 0; e_range = 0;
        exp_ce = 0; exp_we = 0; exp_vld = 0;
        exp_addr = 0; exp_wdata = '0; exp_cdata = '0;
    endtask

    task automatic model_edge();
        int  b, a;
        bit  legal;
        rd_t r;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        exp_vld = 0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            r = rdq.pop_front();
            exp_cdata = r.data;
            exp_vld = 1;
        end
        legal = (csel >= 3'd1) && (csel <= 3'd5);
        b = legal ? int'(csel) - 1 : 0;
        a = cwr ? int'(caddr_wr) : int'(caddr_rd);
        exp_ce = 0;
        if (cwr && crd) e_coll = 1;
        if (cwr || crd) begin
            if (!legal) e_sel = 1;
            else if (a >= size_tab[b]) e_range = 1;
            else begin
                exp_ce = 1;
                exp_we = cwr;
                exp_addr = base_tab[b] + a;
                exp_wdata = cdata_wr;
                if (cwr) begin
                    img[b][a] = cdata_wr;
                    if (!clr_status && cnt[b] < size_tab[b]) cnt[b]++;
                end else begin
                    r.due = cyc + 2;
                    r.data = img[b][a];
                    rdq.push_back(r);
                end
            end
        end
        if (clr_status) begin
            for (int i = 0; i < NBANK; i++) cnt[i] = 0;
            e_coll = 0; e_sel = 0; e_range = 0;
        end
    endtask

    task automatic check_outputs();
        logic [NBANK-1:0] full;
        for (int i = 0; i < NBANK; i++) full[i] = (cnt[i] == size_tab[i]);
        check("sram_ce", 32'(sram_ce), 32'(exp_ce));
        if (exp_ce) begin
            check("sram_we", 32'(sram_we), 32'(exp_we));
            check("sram_addr", 32'(sram_addr), 32'(exp_addr));
            if (exp_we) check("sram_wdata", 32'(sram_wdata), 32'(exp_wdata));
        end
        check("rd_vld", 32'(cdata_rd_vld), 32'(exp_vld));
        check("cdata_rd", 32'(cdata_rd), 32'(exp_cdata));
        check("bank_full", 32'(bank_full), 32'(full));
        check("err_coll", 32'(err_coll), 32'(e_coll));
        check("err_sel", 32'(err_sel), 32'(e_sel));
        check("err_range", 32'(err_range), 32'(e_range));
    endtask

    // One clock: DUT and model see the same sampled inputs, outputs are
    // compared 1 time unit after the edge, then the caller drives new inputs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cwr = 0; crd = 0; clr_status = 0;
        csel = 3'd0; caddr_wr = '0; caddr_rd = '0; cdata_wr = '0;
    endtask

    task automatic drive_wr(input logic [2:0] s, input int a, input logic [DW-1:0] d);
        idle();
        cwr = 1; csel = s; caddr_wr = AW'(a); cdata_wr = d;
    endtask

    task automatic drive_rd(input logic [2:0] s, input int a);
        idle();
        crd = 1; csel = s; caddr_rd = AW'(a);
    endtask

    function automatic int rand_addr(input logic [2:0] s);
        int sz, m, v;
        sz = (s >= 3'd1 && s <= 3'd5) ? size_tab[int'(s) - 1] : 4096;
        m = $urandom_range(0, 3);
        if (m == 1) begin
            v = sz - 2 + int'($urandom_range(0, 3));
            if (v > 4095) v = 4095;
        end else if (m == 2) v = int'($urandom_range(0, 4095));
        else v = int'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        base_tab[0] = 0;
        for (int i = 1; i < NBANK; i++) base_tab[i] = base_tab[i-1] + size_tab[i-1];
        for (int i = 0; i < 2**SAW; i++) sram_mem[i] = '0;
        for (int b = 0; b < NBANK; b++)
            for (int a = 0; a < 4096; a++) img[b][a] = '0;
        sram_rdata = '0;
        cyc = 0;
        model_reset();
        idle();
        reset = 1;

        // Reset state
        step(); step();
        reset = 0;
        $display("reset: outputs checked against zero");

        // 1: single write
        drive_wr(3'b001, 5, 20'h12345);
        step();
        check("t1_ce", 32'(sram_ce), 32'd1);
        check("t1_we", 32'(sram_we), 32'd1);
        check("t1_addr", 32'(sram_addr), 32'd5);
        check("t1_wdata", 32'(sram_wdata), 32'h12345);
        $display("t1: write L0_MEM0[5]=12345");

        // 2: write then read back from L1_MEM0
        drive_wr(3'b011, 7, 20'h0ABCD);
        step();
        drive_rd(3'b011, 7);
        step();
        check("t2_addr", 32'(sram_addr), 32'd8199);
        check("t2_we", 32'(sram_we), 32'd0);
        idle();
        step();
        check("t2_vld_early", 32'(cdata_rd_vld), 32'd0);
        step();
        check("t2_vld", 32'(cdata_rd_vld), 32'd1);
        check("t2_data", 32'(cdata_rd), 32'h0ABCD);
        step();
        check("t2_vld_pulse", 32'(cdata_rd_vld), 32'd0);
        $display("t2: read L1_MEM0[7] -> %0h", cdata_rd);

        // 3: fill L0_MEM1
        for (int i = 0; i < 4096; i++) begin
            drive_wr(3'b010, i, DW'($urandom));
            step();
            if (i == 4094) check("t3_not_full", 32'(bank_full), 32'd0);
        end
        idle();
        step();
        check("t3_full", 32'(bank_full), 32'b00010);
        drive_wr(3'b010, 100, 20'h55555);
        step();
        check("t3_sat", 32'(bank_full), 32'b00010);
        idle();
        clr_status = 1;
        step();
        check("t3_clr", 32'(bank_full), 32'd0);
        $display("t3: L0_MEM1 filled, saturated and cleared");

        // 4: collision
        idle();
        cwr = 1; crd = 1; csel = 3'b101; caddr_wr = 12'd3; caddr_rd = 12'd3; cdata_wr = 20'hFEDCB;
        step();
        check("t4_addr", 32'(sram_addr), 32'd10243);
        check("t4_we", 32'(sram_we), 32'd1);
        check("t4_coll", 32'(err_coll), 32'd1);
        idle();
        step(); step();
        check("t4_no_vld", 32'(cdata_rd_vld), 32'd0);
        $display("t4: collision on L2_MEM[3]");

        // 5: illegal select, out of range
        drive_wr(3'b110, 0, 20'h1);
        step();
        check("t5_sel_ce", 32'(sram_ce), 32'd0);
        check("t5_sel", 32'(err_sel), 32'd1);
        drive_wr(3'b011, 1024, 20'h2);
        step();
        check("t5_rng_ce", 32'(sram_ce), 32'd0);
        check("t5_rng", 32'(err_range), 32'd1);
        $display("t5: illegal csel and out-of-range dropped");

        // 6: reset while a read is in stage S
        drive_wr(3'b001, 9, 20'h9A9A9);
        step();
        drive_rd(3'b001, 9);
        step();
        idle();
        reset = 1;
        model_reset();
        #1;
        check_outputs();
        check("t6_ce", 32'(sram_ce), 32'd0);
        step();
        reset = 0;
        step();
        check("t6_vld", 32'(cdata_rd_vld), 32'd0);
        drive_rd(3'b001, 9);
        step();
        idle();
        step(); step();
        check("t6_data", 32'(cdata_rd), 32'h9A9A9);
        $display("t6: reset mid-read, re-read %0h", cdata_rd);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            cwr = ($urandom_range(0, 99) < 45);
            crd = ($urandom_range(0, 99) < 45);
            csel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
            caddr_wr = AW'(rand_addr(csel));
            caddr_rd = ($urandom_range(0, 1) == 0) ? caddr_wr : AW'(rand_addr(csel));
            cdata_wr = DW'($urandom);
            clr_status = ($urandom_range(0, 49) == 0);
            step();
            if (cdata_rd_vld) $display("rand: cyc=%0d read return %0h", cyc, cdata_rd);
        end
        idle();
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
